// File: rtl/bcd_to_ex3_fifo.sv
// bcd_to_ex3_fifo: small first-word-fall-through buffer that accepts BCD
// digits, stores their Excess-3 codes and presents the oldest one to the
// downstream 2421 converter. Non-BCD inputs (10..15) are dropped and flagged
// with a one-cycle err pulse.
// Optional feature: define BCD_EX3_ERR_CNT_EN to add an 8-bit saturating
// count of err pulses on output err_cnt.
`timescale 1ns/1ps

module bcd_to_ex3_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3:0]              in_bcd,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [3:0]              out_ex,
  output logic                    err,
`ifdef BCD_EX3_ERR_CNT_EN
  output logic [$clog2(DEPTH):0]  count,
  output logic [7:0]              err_cnt
`else
  output logic [$clog2(DEPTH):0]  count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic [3:0]    last_ex_q, last_ex_d;
  logic [3:0]    mem_q [DEPTH];

  logic          in_fire;
  logic          digit_ok;
  logic          push;
  logic          reject;
  logic          pop;

  // Handshake decode: in_ready only looks at occupancy, so a full buffer
  // never accepts even when the consumer is draining in the same cycle.
  always_comb begin
    in_ready  = (count_q < FULL_LEVEL);
    out_valid = (count_q != '0);
    in_fire   = in_valid & in_ready;
    digit_ok  = (in_bcd <= 4'd9);
    push      = in_fire & digit_ok;
    reject    = in_fire & ~digit_ok;
    pop       = out_valid & out_ready;
  end

  // Next-state for pointers, occupancy, error pulse and the hold register
  // that keeps out_ex steady once the buffer has emptied.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    last_ex_d = last_ex_q;
    err_d     = reject;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end

    if (pop) begin
      rd_ptr_d  = rd_ptr_q + AW'(1);
      last_ex_d = mem_q[rd_ptr_q];
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register; reset discards everything buffered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Digit storage and hold register are data only and are never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_bcd + 4'd3;
    end
    last_ex_q <= last_ex_d;
  end

  // Output drive: fall-through head digit while non-empty, last popped
  // digit otherwise.
  always_comb begin
    out_ex = (count_q == '0) ? last_ex_q : mem_q[rd_ptr_q];
    count  = count_q;
    err    = err_q;
  end

`ifdef BCD_EX3_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Count err pulses, sticking at 255.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_q && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Error counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  // Expose the counter.
  always_comb begin
    err_cnt = err_cnt_q;
  end
`else
  // No error counter in this build.
`endif

endmodule
